pc_branch_sequencer: RTL and testbench
======================================

// Module: pc_branch_sequencer
// PURPOSE
//  Consumer end of the branch-decision path: takes the BEQ/BNE control bits and the
//  ALU Zero flag, resolves branch/jump, and owns the registered 16-bit program counter.
//  Sits between control unit/ALU and instruction memory; PC_O drives IMEM address.
//  Adds halt/resume, stall and a boot cycle, so the PC path is sequential.
// PARAMETERS
//  ADDR_W    16      PC width in bits (word-addressed)
//  RESET_PC  16'h0000 PC value loaded on reset
//  OFF_W     8       width of signed branch offset
// PORTS
//  CLK             in   1       system clock, rising edge
//  RST             in   1       async reset, active-high
//  En              in   1       advance enable; 0 = stall (hold PC)
//  BEQ             in   1       branch-if-equal decoded
//  BNE             in   1       branch-if-not-equal decoded
//  Zero_I          in   1       ALU zero flag for current instruction
//  Jump            in   1       unconditional jump decoded
//  Imm_Off         in   OFF_W   signed branch offset (words)
//  Jump_Addr       in   12      jump target low bits
//  Halt_I          in   1       halt instruction decoded
//  Resume_I        in   1       external resume request
//  PC_O            out  ADDR_W  current PC (IMEM address)
//  Fetch_Valid_O   out  1       PC_O is a valid fetch this cycle
//  Branch_Taken_O  out  1       combinational: redirect selected this cycle
//  Halted_O        out  1       FSM in HALT
//  Err_O           out  1       sticky: BEQ and BNE both asserted in RUN
//  Redirect_Cnt_O  out  16      count of taken branches + jumps
// BEHAVIOUR
//  Clock/reset: one clock (CLK); RST asynchronous, active-high.
//  Reset: PC_O=RESET_PC, state=BOOT, Fetch_Valid_O=0, Halted_O=0, Err_O=0,
//   Redirect_Cnt_O=0. Reset mid-operation aborts everything and returns here.
//  FSM: BOOT -> RUN unconditionally after 1 cycle (PC stays RESET_PC, first fetch in RUN).
//   RUN: Fetch_Valid_O=1. HALT: Fetch_Valid_O=0, Halted_O=1.
//  RUN next-PC priority (only when En=1; En=0 holds PC, counter, state):
//   1 Halt_I: PC held, -> HALT.
//   2 Jump: PC <= {PC_plus1[15:12], Jump_Addr}.
//   3 taken = (BEQ & Zero_I) | (BNE & ~Zero_I): PC <= PC + 1 + sext(Imm_Off).
//   4 else PC <= PC + 1.
//  BEQ&BNE both 1: no branch (falls to 4), Err_O set, stays set until RST.
//  Arithmetic modulo 2^ADDR_W: 16'hFFFF+1 -> 16'h0000; negative offsets wrap likewise.
//  Branch_Taken_O = (Jump | taken) & RUN & En & ~Halt_I; counter increments on same
//   condition, saturates at 16'hFFFF.
//  HALT: Resume_I=1 -> RUN, PC <= PC+1 (next instruction). En ignored in HALT.
//   Halt_I ignored outside RUN. Resume_I ignored outside HALT.
//  Latency: redirect visible on PC_O one cycle after decision inputs are sampled.
// STRUCTURE
//  Shared package: state encoding (ST_BOOT, ST_RUN, ST_HALT), RESET_PC default,
//   ADDR_W/OFF_W constants.
//  One sub-module: branch_resolve (combinational: taken, err, target mux).
//  Top: FSM register, PC register, saturating counter.
// TESTING
//  1 RST pulse, En=1, no ctrl -> cycle0 PC=0000 valid=0; then 0000,0001,0002 valid=1.
//  2 PC=0010, BEQ=1 Zero_I=1 Imm_Off=8'hFC -> PC=000D, Branch_Taken_O=1, cnt=1;
//    BNE=1 Zero_I=1 -> PC=0011, not taken.
//  3 PC=FFFF, no ctrl -> 0000; PC=0005 Jump=1 Jump_Addr=12'hABC -> 0ABC.
//  4 Halt_I at PC=0020 -> PC holds 0020, Halted_O=1 for 5 cycles with Jump=1
//    asserted (ignored); Resume_I -> RUN, PC=0021.
//  5 En=0 with BNE=1 Zero_I=0 -> PC and cnt unchanged; BEQ=BNE=1 En=1 -> PC+1, Err_O=1
//    and sticky.
//  6 RST asserted async mid-HALT and mid-branch -> outputs reset without a clock edge.

Source files
------------

// File: rtl/pc_branch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_branch_sequencer_pkg
// Shared definitions for the PC / branch sequencer: sequencer state encoding
// and default widths / reset value used by the top and its resolve sub-block.
// -----------------------------------------------------------------------------
package pc_branch_sequencer_pkg;

   localparam int              DEFAULT_ADDR_W   = 16;       // PC width (word-addressed)
   localparam int              DEFAULT_OFF_W    = 8;        // signed branch offset width
   localparam logic [15:0]     DEFAULT_RESET_PC = 16'h0000; // PC loaded on reset
   localparam int              JADDR_W          = 12;       // jump target low bits
   localparam int              CNT_W            = 16;       // redirect counter width

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/pc_branch_sequencer_branch_resolve.sv
// -----------------------------------------------------------------------------
// pc_branch_sequencer_branch_resolve
// Purely combinational branch/jump resolution for the current PC.
// Ports:
//   pc_i        current PC
//   beq_i/bne_i decoded conditional branch kinds
//   zero_i      ALU zero flag
//   jump_i      decoded unconditional jump
//   imm_off_i   signed branch offset in words
//   jump_addr_i low bits of the jump target
//   pc_plus1_o  sequential successor of pc_i
//   next_pc_o   selected next PC (jump > taken branch > PC+1)
//   redirect_o  jump or taken branch selected
//   err_o       BEQ and BNE decoded together (illegal encoding)
// -----------------------------------------------------------------------------
module pc_branch_sequencer_branch_resolve
   import pc_branch_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int OFF_W  = DEFAULT_OFF_W
) (
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               beq_i,
   input  logic               bne_i,
   input  logic               zero_i,
   input  logic               jump_i,
   input  logic [OFF_W-1:0]   imm_off_i,
   input  logic [JADDR_W-1:0] jump_addr_i,
   output logic [ADDR_W-1:0]  pc_plus1_o,
   output logic [ADDR_W-1:0]  next_pc_o,
   output logic               redirect_o,
   output logic               err_o
);

   logic              taken;
   logic [ADDR_W-1:0] offset_sext;

   // NOTE: every signal written in an always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      pc_plus1_o  = pc_i + ADDR_W'(1);
      offset_sext = {{(ADDR_W-OFF_W){imm_off_i[OFF_W-1]}}, imm_off_i};
      err_o       = beq_i & bne_i;
      // Both conditions decoded at once is meaningless; treat as no branch.
      taken       = ((beq_i & zero_i) | (bne_i & ~zero_i)) & ~err_o;
      redirect_o  = jump_i | taken;

      next_pc_o = pc_plus1_o;
      if (jump_i) begin
         // Jump keeps the page (upper bits) of the sequential successor.
         next_pc_o = {pc_plus1_o[ADDR_W-1:JADDR_W], jump_addr_i};
      end else if (taken) begin
         next_pc_o = pc_plus1_o + offset_sext;   // wraps modulo 2^ADDR_W
      end
   end

endmodule

// File: rtl/pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_branch_sequencer
// Owns the registered program counter feeding instruction memory. Resolves
// BEQ/BNE/Jump against the ALU zero flag, supports stall (En), halt/resume and
// a one-cycle boot state after reset.
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   En              advance enable in RUN; 0 holds PC, counter and state
//   BEQ, BNE, Zero_I, Jump, Imm_Off, Jump_Addr   branch/jump decision inputs
//   Halt_I          halt request (honoured in RUN only)
//   Resume_I        resume request (honoured in HALT only)
//   PC_O            current PC / IMEM address
//   Fetch_Valid_O   PC_O is a valid fetch (RUN)
//   Branch_Taken_O  combinational: redirect selected this cycle
//   Halted_O        sequencer is in HALT
//   Err_O           sticky: BEQ and BNE seen together in RUN
//   Redirect_Cnt_O  saturating count of taken branches and jumps
// -----------------------------------------------------------------------------
module pc_branch_sequencer
   import pc_branch_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int                OFF_W    = DEFAULT_OFF_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               En,
   input  logic               BEQ,
   input  logic               BNE,
   input  logic               Zero_I,
   input  logic               Jump,
   input  logic [OFF_W-1:0]   Imm_Off,
   input  logic [JADDR_W-1:0] Jump_Addr,
   input  logic               Halt_I,
   input  logic               Resume_I,
   output logic [ADDR_W-1:0]  PC_O,
   output logic               Fetch_Valid_O,
   output logic               Branch_Taken_O,
   output logic               Halted_O,
   output logic               Err_O,
   output logic [CNT_W-1:0]   Redirect_Cnt_O
);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               fetch_valid_q, fetch_valid_d;
   logic               halted_q, halted_d;

   logic [ADDR_W-1:0]  pc_plus1;
   logic [ADDR_W-1:0]  next_pc;
   logic               redirect;
   logic               both_cond;

   pc_branch_sequencer_branch_resolve #(
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W)
   ) u_resolve (
      .pc_i        (pc_q),
      .beq_i       (BEQ),
      .bne_i       (BNE),
      .zero_i      (Zero_I),
      .jump_i      (Jump),
      .imm_off_i   (Imm_Off),
      .jump_addr_i (Jump_Addr),
      .pc_plus1_o  (pc_plus1),
      .next_pc_o   (next_pc),
      .redirect_o  (redirect),
      .err_o       (both_cond)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      err_d          = err_q;
      Branch_Taken_O = 1'b0;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;   // PC stays RESET_PC; first fetch happens in RUN
         ST_RUN: begin
            if (both_cond) err_d = 1'b1;
            if (En) begin
               if (Halt_I) begin
                  state_d = ST_HALT;   // PC held on the halt instruction
               end else begin
                  pc_d = next_pc;
                  if (redirect) begin
                     Branch_Taken_O = 1'b1;
                     if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         ST_HALT: begin
            // En has no effect here; only a resume wakes the sequencer.
            if (Resume_I) begin
               state_d = ST_RUN;
               pc_d    = pc_plus1;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      fetch_valid_d = (state_d == ST_RUN);
      halted_d      = (state_d == ST_HALT);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         fetch_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         fetch_valid_q <= fetch_valid_d;
         halted_q      <= halted_d;
      end
   end

   assign PC_O           = pc_q;
   assign Fetch_Valid_O  = fetch_valid_q;
   assign Halted_O       = halted_q;
   assign Err_O          = err_q;
   assign Redirect_Cnt_O = cnt_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_sequencer
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected observable state for each cycle into a scoreboard queue; a monitor
// pops and compares mid-cycle (on the falling edge).
// -----------------------------------------------------------------------------
module tb_pc_branch_sequencer;

   typedef struct packed {
      logic [15:0] tag;
      logic [15:0] pc;
      logic        valid;
      logic        halted;
      logic        err;
      logic [15:0] cnt;
      logic        taken;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        En = 1'b0, BEQ = 1'b0, BNE = 1'b0, Zero_I = 1'b0, Jump = 1'b0;
   logic [7:0]  Imm_Off = '0;
   logic [11:0] Jump_Addr = '0;
   logic        Halt_I = 1'b0, Resume_I = 1'b0;
   logic [15:0] PC_O;
   logic        Fetch_Valid_O, Branch_Taken_O, Halted_O, Err_O;
   logic [15:0] Redirect_Cnt_O;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step_no  = 0;

   pc_branch_sequencer dut (
      .CLK            (CLK),
      .RST            (RST),
      .En             (En),
      .BEQ            (BEQ),
      .BNE            (BNE),
      .Zero_I         (Zero_I),
      .Jump           (Jump),
      .Imm_Off        (Imm_Off),
      .Jump_Addr      (Jump_Addr),
      .Halt_I         (Halt_I),
      .Resume_I       (Resume_I),
      .PC_O           (PC_O),
      .Fetch_Valid_O  (Fetch_Valid_O),
      .Branch_Taken_O (Branch_Taken_O),
      .Halted_O       (Halted_O),
      .Err_O          (Err_O),
      .Redirect_Cnt_O (Redirect_Cnt_O)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, tag, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic beq, input logic bne, input logic z,
                        input logic jmp, input logic [7:0] imm, input logic [11:0] ja,
                        input logic hlt, input logic res);
      En = en; BEQ = beq; BNE = bne; Zero_I = z; Jump = jmp;
      Imm_Off = imm; Jump_Addr = ja; Halt_I = hlt; Resume_I = res;
   endtask

   // Drive this cycle's inputs, record what the DUT must show during this
   // cycle, then advance to just after the next rising edge.
   task automatic step(input logic en, input logic beq, input logic bne, input logic z,
                       input logic jmp, input logic [7:0] imm, input logic [11:0] ja,
                       input logic hlt, input logic res,
                       input logic [15:0] e_pc, input logic e_v, input logic e_h,
                       input logic e_err, input logic [15:0] e_cnt, input logic e_tk);
      exp_t e;
      drive(en, beq, bne, z, jmp, imm, ja, hlt, res);
      step_no++;
      e = '{tag: 16'(step_no), pc: e_pc, valid: e_v, halted: e_h, err: e_err, cnt: e_cnt, taken: e_tk};
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_pc"},     step_no, 32'(PC_O), 32'h0000);
      check({name, "_valid"},  step_no, 32'(Fetch_Valid_O), 32'd0);
      check({name, "_halted"}, step_no, 32'(Halted_O), 32'd0);
      check({name, "_err"},    step_no, 32'(Err_O), 32'd0);
      check({name, "_cnt"},    step_no, 32'(Redirect_Cnt_O), 32'd0);
      check({name, "_taken"},  step_no, 32'(Branch_Taken_O), 32'd0);
   endtask

   // Monitor: compares the oldest expectation against the DUT mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",     int'(e.tag), 32'(PC_O),           32'(e.pc));
            check("valid",  int'(e.tag), 32'(Fetch_Valid_O),  32'(e.valid));
            check("halted", int'(e.tag), 32'(Halted_O),       32'(e.halted));
            check("err",    int'(e.tag), 32'(Err_O),          32'(e.err));
            check("cnt",    int'(e.tag), 32'(Redirect_Cnt_O), 32'(e.cnt));
            check("taken",  int'(e.tag), 32'(Branch_Taken_O), 32'(e.taken));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      // Reset applied from time 0.
      #1;
      check_reset_state("por");
      @(posedge CLK); #1;
      RST = 1'b0;

      //    en beq bne z jmp imm    ja      hlt res   pc       v  h  e  cnt tk
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 0, 0, 0, 0,  0); // BOOT
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 1, 0, 0, 0,  0); // first fetch
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0001, 1, 0, 0, 0,  0);
      step(1, 0, 0, 0, 1, 8'h00, 12'h010, 0, 0,  16'h0002, 1, 0, 0, 0,  1); // jump -> 0010
      step(1, 1, 0, 1, 0, 8'hFC, 12'h000, 0, 0,  16'h0010, 1, 0, 0, 1,  1); // BEQ taken -> 000D
      step(1, 0, 1, 1, 0, 8'hFC, 12'h000, 0, 0,  16'h000D, 1, 0, 0, 2,  0); // BNE not taken
      step(1, 1, 0, 0, 0, 8'hFC, 12'h000, 0, 0,  16'h000E, 1, 0, 0, 2,  0); // BEQ not taken
      step(1, 0, 1, 0, 0, 8'h10, 12'h000, 0, 0,  16'h000F, 1, 0, 0, 2,  1); // BNE taken -> 0020
      step(1, 0, 0, 0, 1, 8'h00, 12'h123, 1, 0,  16'h0020, 1, 0, 0, 3,  0); // halt beats jump
      for (int i = 0; i < 5; i++)
         step(1, 0, 0, 0, 1, 8'h00, 12'h123, 0, 0, 16'h0020, 0, 1, 0, 3, 0); // jump ignored
      step(0, 0, 0, 0, 0, 8'h00, 12'h000, 0, 1,  16'h0020, 0, 1, 0, 3,  0); // resume, En ignored
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 1,  16'h0021, 1, 0, 0, 3,  0); // resume ignored in RUN
      step(0, 0, 1, 0, 0, 8'h10, 12'h000, 0, 0,  16'h0022, 1, 0, 0, 3,  0); // stall
      step(1, 1, 1, 1, 0, 8'h10, 12'h000, 0, 0,  16'h0022, 1, 0, 0, 3,  0); // BEQ&BNE -> PC+1, err
      step(1, 1, 0, 1, 0, 8'hDC, 12'h000, 0, 0,  16'h0023, 1, 0, 1, 3,  1); // -> 0000
      step(1, 0, 1, 0, 0, 8'hFE, 12'h000, 0, 0,  16'h0000, 1, 0, 1, 4,  1); // wrap down -> FFFF
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'hFFFF, 1, 0, 1, 5,  0); // wrap up -> 0000
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 1, 0, 1, 5,  0);
      step(1, 1, 0, 1, 0, 8'h03, 12'h000, 0, 0,  16'h0001, 1, 0, 1, 5,  1); // -> 0005
      step(1, 0, 0, 0, 1, 8'h00, 12'hABC, 0, 0,  16'h0005, 1, 0, 1, 6,  1); // jump -> 0ABC
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 1, 0,  16'h0ABC, 1, 0, 1, 7,  0); // halt
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0ABC, 0, 1, 1, 7,  0); // in HALT

      // Asynchronous reset mid-HALT, away from any clock edge.
      #2;
      RST = 1'b1;
      #1;
      check_reset_state("rst_halt");
      @(posedge CLK); #1;
      RST = 1'b0;

      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 0, 0, 0, 0,  0); // BOOT again
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 1, 0, 0, 0,  0);

      // Asynchronous reset while a branch decision is being presented.
      drive(1, 0, 1, 0, 0, 8'h05, 12'h000, 0, 0);
      #1;
      check("pre_rst_taken", step_no, 32'(Branch_Taken_O), 32'd1);
      check("pre_rst_pc",    step_no, 32'(PC_O), 32'h0001);
      #1;
      RST = 1'b1;
      #1;
      check_reset_state("rst_branch");
      drive(0, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0);
      @(posedge CLK); #1;
      RST = 1'b0;

      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 0, 0, 0, 0,  0);
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0000, 1, 0, 0, 0,  0);
      step(1, 0, 0, 0, 0, 8'h00, 12'h000, 0, 0,  16'h0001, 1, 0, 0, 0,  0);

      @(negedge CLK); #1;
      check("scoreboard_drained", step_no, 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
